avalon_draw_queue: RTL and testbench
====================================

// Module: avalon_draw_queue
// PURPOSE
//  Avalon-MM slave that queues sprite draw commands (img_id, x, y) in a DEPTH-entry FIFO and
//  issues them one at a time to the graphics accelerator over a start/done handshake. It also
//  latches frame events with a sticky pending flag, ack and missed-frame count. Sits between the
//  NIOS-side Avalon bus and graphics_accelerator; software no longer waits on each Done per sprite.
// PARAMETERS
//  DEPTH     16  command FIFO entries (power of 2, >=2)
//  IMG_ID_W   8  image id width
//  COORD_W   10  x/y coordinate width
//  CNT_W      8  width of missed-frame counter (saturating)
// PORTS
//  Clk            in   1         clock
//  RESET          in   1         asynchronous, active-high reset
//  AVL_READ       in   1         Avalon read
//  AVL_WRITE      in   1         Avalon write
//  AVL_CS         in   1         chip select
//  AVL_BYTE_EN    in   4         byte enables
//  AVL_ADDR       in   3         word address
//  AVL_WRITEDATA  in   32        write data
//  AVL_READDATA   out  32        read data, 1-cycle read latency
//  GFX_START      out  1         command valid to accelerator
//  GFX_IMG_ID     out  IMG_ID_W  image id of issued command
//  GFX_X, GFX_Y   out  COORD_W   coordinates of issued command
//  GFX_DONE       in   1         accelerator done (level)
//  FRAME_PULSE    in   1         frame clock from VGA side (already in Clk domain)
//  IRQ            out  1         frame_pending & irq_en
// BEHAVIOUR
//  Register map (word addr):
//   0 IMG_ID stage RW | 1 X stage RW | 2 Y stage RW
//   3 PUSH   WO: any write with CS pushes {IMG_ID,X,Y} staged values; reads 0
//   4 STATUS RO [0]busy [1]empty [2]full [3]frame_pending [4]overflow [15:8]fifo count;
//     writing 1 to bit4 clears overflow (only W1C bit)
//   5 FRAME_ACK WO: write with bit0=1 clears frame_pending and missed count
//   6 CONTROL RW [0]enable [1]flush (self-clearing) [2]irq_en
//   7 MISSED RO: frames seen while pending (saturates at 2^CNT_W-1)
//  Stage/CONTROL writes honour AVL_BYTE_EN per byte lane; bits above field width read 0.
//  Reads: AVL_READDATA registered; valid the cycle after AVL_CS&AVL_READ, else 0.
//  Reset: all registers, FIFO pointers, count, flags, GFX_* outputs, IRQ, AVL_READDATA = 0;
//   FSM -> IDLE. Reset mid-command drops GFX_START immediately; FIFO contents lost.
//  FIFO: push when not full -> count+1; push when full -> dropped, overflow<=1, unless a pop
//   occurs same cycle (then accepted). Push and pop same cycle when not full: count unchanged.
//   Pointers wrap modulo DEPTH.
//  Flush: empties FIFO in 1 cycle; in-flight command completes normally; flush wins over push
//   in same cycle.
//  Issuer FSM:
//   IDLE    : enable & !empty -> pop head into GFX_* regs, -> ISSUE
//   ISSUE   : GFX_START=1; GFX_DONE=1 -> RELEASE
//   RELEASE : GFX_START=0; wait GFX_DONE=0 -> IDLE
//   busy = (state!=IDLE). Clearing enable stops new issues only; never aborts ISSUE.
//   Min spacing between commands: pop->START same cycle as ISSUE entry, 3 cycles per command
//   with zero-latency done.
//  Frame: rising edge of FRAME_PULSE (registered edge detect, 1 cycle) sets frame_pending;
//   edge while already pending -> missed+1 (saturating). Edge and ACK same cycle: pending stays
//   1, missed cleared to 0.
// TESTING
//  1 Reset; read STATUS -> 0x0002 (empty); read MISSED -> 0; GFX_START=0, IRQ=0.
//  2 Stage (5,100,200), push, enable; GFX_START rises with id5,x100,y200; done pulse after
//    4 cycles -> START drops, FSM IDLE, STATUS busy=0.
//  3 enable=0, push 17 cmds (DEPTH16) -> count=16, full=1, overflow=1; W1C bit4 -> overflow=0;
//    enable and drain -> commands issued in push order 0..15.
//  4 Push at full with simultaneous pop -> accepted, count stays 16, overflow stays 0.
//  5 Three FRAME_PULSE edges without ack -> pending=1, MISSED=2, IRQ=1 if irq_en; ACK coincident
//    with a 4th edge -> pending=1, MISSED=0.
//  6 Flush during ISSUE with 3 queued -> count=0 next cycle; current command completes on done;
//    assert RESET mid-ISSUE -> GFX_START=0 asynchronously.

Source files
------------

// File: rtl/avalon_draw_queue.sv
// Avalon-MM sprite draw queue: buffers (img_id, x, y) commands in a FIFO, issues them one at a
// time to the graphics accelerator over start/done, and tracks frame events for the CPU.
module avalon_draw_queue #(
  parameter int DEPTH    = 16,
  parameter int IMG_ID_W = 8,
  parameter int COORD_W  = 10,
  parameter int CNT_W    = 8
) (
  input  logic                Clk,
  input  logic                RESET,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic                AVL_CS,
  input  logic [3:0]          AVL_BYTE_EN,
  input  logic [2:0]          AVL_ADDR,
  input  logic [31:0]         AVL_WRITEDATA,
  output logic [31:0]         AVL_READDATA,
  output logic                GFX_START,
  output logic [IMG_ID_W-1:0] GFX_IMG_ID,
  output logic [COORD_W-1:0]  GFX_X,
  output logic [COORD_W-1:0]  GFX_Y,
  input  logic                GFX_DONE,
  input  logic                FRAME_PULSE,
  output logic                IRQ
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMD_W = IMG_ID_W + 2 * COORD_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  state_t               r_state, w_next;
  logic [IMG_ID_W-1:0]  r_stage_id, r_gfx_id;
  logic [COORD_W-1:0]   r_stage_x, r_stage_y, r_gfx_x, r_gfx_y;
  logic                 r_enable, r_irq_en, r_overflow, r_pending, r_frame_d;
  logic [CNT_W-1:0]     r_missed;
  logic [CMD_W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [31:0]          r_readdata;

  logic        w_wr, w_push, w_push_ok, w_pop, w_flush, w_ovf_clr, w_ack;
  logic        w_empty, w_full, w_busy, w_frame_edge;
  logic [31:0] w_wmask, w_rdata, w_status;
  logic [7:0]  w_count8;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_wr      = AVL_CS & AVL_WRITE;
  assign w_wmask   = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}}, {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
  assign w_push    = w_wr && (AVL_ADDR == 3'd3);
  assign w_flush   = w_wr && (AVL_ADDR == 3'd6) && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];
  assign w_ovf_clr = w_wr && (AVL_ADDR == 3'd4) && AVL_WRITEDATA[4];
  assign w_ack     = w_wr && (AVL_ADDR == 3'd5) && AVL_WRITEDATA[0];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = (r_state == S_IDLE) && r_enable && !w_empty;
  // A push at full is still accepted when the issuer frees the head slot in the same cycle.
  assign w_push_ok = w_push && !w_flush && (!w_full || w_pop);

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_stage_id <= '0;
      r_stage_x  <= '0;
      r_stage_y  <= '0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
    end else if (w_wr) begin
      case (AVL_ADDR)
        3'd0: r_stage_id <= IMG_ID_W'(f_merge(32'(r_stage_id), AVL_WRITEDATA, w_wmask));
        3'd1: r_stage_x  <= COORD_W'(f_merge(32'(r_stage_x), AVL_WRITEDATA, w_wmask));
        3'd2: r_stage_y  <= COORD_W'(f_merge(32'(r_stage_y), AVL_WRITEDATA, w_wmask));
        3'd6: if (AVL_BYTE_EN[0]) begin
          r_enable <= AVL_WRITEDATA[0];
          r_irq_en <= AVL_WRITEDATA[2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {r_stage_id, r_stage_x, r_stage_y};
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
      if (w_push && !w_flush && w_full && !w_pop) r_overflow <= 1'b1;
      else if (w_ovf_clr)                         r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_gfx_id <= '0;
      r_gfx_x  <= '0;
      r_gfx_y  <= '0;
    end else if (w_pop) begin
      {r_gfx_id, r_gfx_x, r_gfx_y} <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pop)     w_next = S_ISSUE;
      S_ISSUE:   if (GFX_DONE)  w_next = S_RELEASE;
      S_RELEASE: if (!GFX_DONE) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    GFX_START = (r_state == S_ISSUE);
    w_busy    = (r_state != S_IDLE);
  end

  assign w_frame_edge = FRAME_PULSE & ~r_frame_d;

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_frame_d <= 1'b0;
      r_pending <= 1'b0;
      r_missed  <= '0;
    end else begin
      r_frame_d <= FRAME_PULSE;
      if (w_ack) begin
        r_pending <= w_frame_edge;
        r_missed  <= '0;
      end else if (w_frame_edge) begin
        if (r_pending && (r_missed != '1)) r_missed <= r_missed + 1'b1;
        r_pending <= 1'b1;
      end
    end
  end

  assign w_count8 = 8'(r_count);
  assign w_status = 32'({w_count8, 3'b000, r_overflow, r_pending, w_full, w_empty, w_busy});

  always_comb begin
    w_rdata = '0;
    case (AVL_ADDR)
      3'd0:    w_rdata = 32'(r_stage_id);
      3'd1:    w_rdata = 32'(r_stage_x);
      3'd2:    w_rdata = 32'(r_stage_y);
      3'd4:    w_rdata = w_status;
      3'd6:    w_rdata = {29'd0, r_irq_en, 1'b0, r_enable};
      3'd7:    w_rdata = 32'(r_missed);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) r_readdata <= '0;
    else       r_readdata <= (AVL_CS && AVL_READ) ? w_rdata : '0;
  end

  assign AVL_READDATA = r_readdata;
  assign GFX_IMG_ID   = r_gfx_id;
  assign GFX_X        = r_gfx_x;
  assign GFX_Y        = r_gfx_y;
  assign IRQ          = r_pending & r_irq_en;

endmodule

// File: tb/tb_avalon_draw_queue.sv
// Bench for avalon_draw_queue: Avalon register traffic plus an accelerator responder that
// checks issued commands against a queue of expected commands built as pushes are driven.
module tb_avalon_draw_queue;

  logic        Clk = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [2:0]  AVL_ADDR = 3'd0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic        GFX_START;
  logic [7:0]  GFX_IMG_ID;
  logic [9:0]  GFX_X, GFX_Y;
  logic        GFX_DONE = 1'b0;
  logic        FRAME_PULSE = 1'b0;
  logic        IRQ;

  typedef struct packed {
    logic [7:0] id;
    logic [9:0] x;
    logic [9:0] y;
  } cmd_t;

  cmd_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  avalon_draw_queue #(.DEPTH(16), .IMG_ID_W(8), .COORD_W(10), .CNT_W(8)) dut (
    .Clk(Clk), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .GFX_START(GFX_START), .GFX_IMG_ID(GFX_IMG_ID),
    .GFX_X(GFX_X), .GFX_Y(GFX_Y), .GFX_DONE(GFX_DONE), .FRAME_PULSE(FRAME_PULSE), .IRQ(IRQ)
  );

  always #5 Clk = ~Clk;

  task automatic avl_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic stage_push(input int id, input int x, input int y, input bit accept);
    cmd_t c;
    avl_write(3'd0, 32'(id), 4'hF);
    avl_write(3'd1, 32'(x), 4'hF);
    avl_write(3'd2, 32'(y), 4'hF);
    avl_write(3'd3, 32'd0, 4'hF);
    if (accept) begin
      c.id = id[7:0]; c.x = x[9:0]; c.y = y[9:0];
      sb.push_back(c);
    end
  endtask

  task automatic wait_start(output bit seen);
    int n = 0;
    while (GFX_START !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    seen = (GFX_START === 1'b1);
  endtask

  // Accelerator model: accept one command, compare with the scoreboard head, answer with done.
  task automatic serve_cmd(input int delay);
    bit   seen;
    cmd_t exp, got;
    wait_start(seen);
    n_cmp++;
    if (!seen) begin
      $display("FAIL issue_timeout: GFX_START=%b, required 1 within 200 cycles", GFX_START);
      n_mis++;
      return;
    end
    got = {GFX_IMG_ID, GFX_X, GFX_Y};
    if (sb.size() == 0) begin
      $display("FAIL unexpected_cmd: got id=%0d x=%0d y=%0d, required none", got.id, got.x, got.y);
      n_mis++;
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        $display("FAIL cmd_order: got id=%0d x=%0d y=%0d, required id=%0d x=%0d y=%0d",
                 got.id, got.x, got.y, exp.id, exp.x, exp.y);
        n_mis++;
      end
    end
    repeat (delay) @(negedge Clk);
    GFX_DONE = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (GFX_START !== 1'b0) begin
      $display("FAIL start_drop: GFX_START=%b after done, required 0", GFX_START);
      n_mis++;
    end
    GFX_DONE = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({GFX_START, IRQ, AVL_READDATA, GFX_IMG_ID, GFX_X, GFX_Y} !== 62'd0) begin
      $display("FAIL reset_outputs: start=%b irq=%b rd=%h id=%h x=%h y=%h, required all 0",
               GFX_START, IRQ, AVL_READDATA, GFX_IMG_ID, GFX_X, GFX_Y);
      n_mis++;
    end
    RESET = 1'b0;
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL reset_status: got %h, required 00000002", d); n_mis++;
    end
    avl_read(3'd7, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL reset_missed: got %h, required 0", d); n_mis++;
    end
  endtask

  task automatic test_single_issue();
    logic [31:0] d;
    stage_push(5, 100, 200, 1'b1);
    avl_write(3'd6, 32'h1, 4'hF);
    serve_cmd(4);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL single_idle_status: got %h, required 00000002", d); n_mis++;
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    avl_write(3'd1, 32'hFFFF_FFFF, 4'b0001);
    avl_read(3'd1, d);
    n_cmp++;
    if (d !== 32'h0000_00FF) begin
      $display("FAIL be_x_lane0: got %h, required 000000ff", d); n_mis++;
    end
    avl_write(3'd1, 32'hFFFF_FFFF, 4'b0010);
    avl_read(3'd1, d);
    n_cmp++;
    if (d !== 32'h0000_03FF) begin
      $display("FAIL be_x_lane1: got %h, required 000003ff", d); n_mis++;
    end
    avl_write(3'd0, 32'hABCD_1234, 4'hF);
    avl_read(3'd0, d);
    n_cmp++;
    if (d !== 32'h0000_0034) begin
      $display("FAIL be_id_width: got %h, required 00000034", d); n_mis++;
    end
    avl_write(3'd6, 32'hFFFF_FFFF, 4'b1110);
    avl_read(3'd6, d);
    n_cmp++;
    if (d !== 32'h0000_0001) begin
      $display("FAIL be_control_masked: got %h, required 00000001", d); n_mis++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    avl_write(3'd6, 32'h0, 4'hF);
    for (int i = 0; i < 17; i++) stage_push(i, i * 3 + 1, 1000 - i, i < 16);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_1014) begin
      $display("FAIL ovf_status_full: got %h, required 00001014", d); n_mis++;
    end
    avl_write(3'd4, 32'h10, 4'hF);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_1004) begin
      $display("FAIL ovf_w1c: got %h, required 00001004", d); n_mis++;
    end
    avl_write(3'd6, 32'h1, 4'hF);
    for (int i = 0; i < 16; i++) serve_cmd(0);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002 || sb.size() != 0) begin
      $display("FAIL ovf_drained: status %h left %0d, required 00000002 left 0", d, sb.size());
      n_mis++;
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    cmd_t c;
    avl_write(3'd6, 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) stage_push(40 + i, i, i * 7, 1'b1);
    avl_write(3'd0, 32'd99, 4'hF);
    avl_write(3'd1, 32'd511, 4'hF);
    avl_write(3'd2, 32'd777, 4'hF);
    // enable lands one edge before the push, so the first pop coincides with the push at full
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_BYTE_EN = 4'hF; AVL_ADDR = 3'd6; AVL_WRITEDATA = 32'h1;
    @(negedge Clk);
    AVL_ADDR = 3'd3; AVL_WRITEDATA = 32'h0;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    c.id = 8'd99; c.x = 10'd511; c.y = 10'd777;
    sb.push_back(c);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_1005) begin
      $display("FAIL full_push_pop_status: got %h, required 00001005", d); n_mis++;
    end
    for (int i = 0; i < 17; i++) serve_cmd(1);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL full_push_pop_drained: got %h, required 00000002", d); n_mis++;
    end
  endtask

  task automatic frame_edge();
    @(negedge Clk); FRAME_PULSE = 1'b1;
    @(negedge Clk);
    @(negedge Clk); FRAME_PULSE = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_frame();
    logic [31:0] d;
    avl_write(3'd6, 32'h5, 4'hF);
    repeat (3) frame_edge();
    avl_read(3'd7, d);
    n_cmp++;
    if (d !== 32'd2) begin
      $display("FAIL frame_missed: got %0d, required 2", d); n_mis++;
    end
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_000A || IRQ !== 1'b1) begin
      $display("FAIL frame_pending: status %h irq %b, required 0000000a irq 1", d, IRQ);
      n_mis++;
    end
    @(negedge Clk);
    FRAME_PULSE = 1'b1;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_BYTE_EN = 4'hF; AVL_ADDR = 3'd5; AVL_WRITEDATA = 32'h1;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    @(negedge Clk);
    FRAME_PULSE = 1'b0;
    avl_read(3'd7, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL frame_ack_edge_missed: got %0d, required 0", d); n_mis++;
    end
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_000A) begin
      $display("FAIL frame_ack_edge_pending: got %h, required 0000000a", d); n_mis++;
    end
    avl_write(3'd5, 32'h1, 4'hF);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002 || IRQ !== 1'b0) begin
      $display("FAIL frame_ack_clear: status %h irq %b, required 00000002 irq 0", d, IRQ);
      n_mis++;
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] d;
    bit          seen;
    int          highs;
    avl_write(3'd6, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) stage_push(200 + i, 10 * i, 20 * i, 1'b1);
    avl_write(3'd6, 32'h5, 4'hF);
    wait_start(seen);
    avl_write(3'd6, 32'h7, 4'hF);
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0003 || GFX_START !== 1'b1) begin
      $display("FAIL flush_status: status %h start %b, required 00000003 start 1", d, GFX_START);
      n_mis++;
    end
    while (sb.size() > 1) void'(sb.pop_back());
    serve_cmd(2);
    highs = 0;
    repeat (10) begin
      @(negedge Clk);
      if (GFX_START) highs++;
    end
    n_cmp++;
    if (highs != 0) begin
      $display("FAIL flush_no_issue: start high %0d cycles, required 0", highs); n_mis++;
    end
    avl_read(3'd6, d);
    n_cmp++;
    if (d !== 32'h0000_0005) begin
      $display("FAIL flush_selfclear: got %h, required 00000005", d); n_mis++;
    end
    stage_push(77, 300, 400, 1'b1);
    wait_start(seen);
    n_cmp++;
    if (!seen || GFX_IMG_ID !== 8'd77) begin
      $display("FAIL pre_reset_issue: start %b id %0d, required 1 id 77", GFX_START, GFX_IMG_ID);
      n_mis++;
    end
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if (GFX_START !== 1'b0 || GFX_IMG_ID !== 8'd0) begin
      $display("FAIL async_reset: start %b id %0d, required 0 id 0", GFX_START, GFX_IMG_ID);
      n_mis++;
    end
    @(negedge Clk);
    RESET = 1'b0;
    sb.delete();
    avl_read(3'd4, d);
    n_cmp++;
    if (d !== 32'h0000_0002) begin
      $display("FAIL post_reset_status: got %h, required 00000002", d); n_mis++;
    end
    avl_read(3'd6, d);
    n_cmp++;
    if (d !== 32'h0000_0000) begin
      $display("FAIL post_reset_control: got %h, required 00000000", d); n_mis++;
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_byte_enable();
    test_overflow();
    test_push_pop_full();
    test_frame();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
